// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : RV32I field-set to instruction-word encoder. Tags each word with
//            a sequential byte address and buffers it in a 2-entry FIFO.
//            Optional macro INSTR_ENC_RANGE_CHECK_EN enables immediate range
//            checking (err_code 10); otherwise immediates are truncated.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int INSTR_WIDTH   = 32,
    parameter int REG_NAME_BITS = 5,
    parameter int FUNC_BITS     = 3,
    parameter int OP_BITS       = 7,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_BITS-1:0]       op,
    input  logic [REG_NAME_BITS-1:0] rd,
    input  logic [REG_NAME_BITS-1:0] rs1,
    input  logic [REG_NAME_BITS-1:0] rs2,
    input  logic [FUNC_BITS-1:0]     funct3,
    input  logic                     alt_op,
    input  logic [INSTR_WIDTH-1:0]   imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [ADDR_WIDTH-1:0]    out_addr,
    output logic                     busy,
    output logic                     err,
    output logic [1:0]               err_code,
    input  logic                     err_clr
);

    localparam logic [OP_BITS-1:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [OP_BITS-1:0] c_OP_MISC   = 7'b0001111;
    localparam logic [OP_BITS-1:0] c_OP_IMM    = 7'b0010011;
    localparam logic [OP_BITS-1:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [OP_BITS-1:0] c_OP_STORE  = 7'b0100011;
    localparam logic [OP_BITS-1:0] c_OP_REG    = 7'b0110011;
    localparam logic [OP_BITS-1:0] c_OP_LUI    = 7'b0110111;
    localparam logic [OP_BITS-1:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [OP_BITS-1:0] c_OP_JALR   = 7'b1100111;
    localparam logic [OP_BITS-1:0] c_OP_JAL    = 7'b1101111;
    localparam logic [OP_BITS-1:0] c_OP_SYSTEM = 7'b1110011;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_STEP = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_RUN   = 2'd1,
        c_DRAIN = 2'd2
    } state_t;

    state_t                              r_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]               r_cnt_q, w_cnt_d;
    logic [1:0][INSTR_WIDTH-1:0]         r_mem_instr_q, w_mem_instr_d;
    logic [1:0][ADDR_WIDTH-1:0]          r_mem_addr_q, w_mem_addr_d;
    logic                                r_wr_ptr_q, w_wr_ptr_d;
    logic                                r_rd_ptr_q, w_rd_ptr_d;
    logic [1:0]                          r_count_q, w_count_d;
    logic                                r_err_q, w_err_d;
    logic [1:0]                          r_err_code_q, w_err_code_d;

    logic [INSTR_WIDTH-1:0]              w_enc;
    logic                                w_illegal;
    logic                                w_range_err;
    logic                                w_accept;
    logic                                w_push;
    logic                                w_pop;

    always_comb begin
        w_enc     = '0;
        w_illegal = 1'b0;
        case (op)
            c_OP_REG:
                w_enc = {1'b0, alt_op & ((funct3 == 3'b000) | (funct3 == 3'b101)),
                         5'b00000, rs2, rs1, funct3, rd, op};
            c_OP_IMM: begin
                if (funct3 == 3'b001)
                    w_enc = {7'b0000000, imm[4:0], rs1, funct3, rd, op};
                else if (funct3 == 3'b101)
                    w_enc = {1'b0, alt_op, 5'b00000, imm[4:0], rs1, funct3, rd, op};
                else
                    w_enc = {imm[11:0], rs1, funct3, rd, op};
            end
            c_OP_JALR, c_OP_LOAD, c_OP_MISC, c_OP_SYSTEM:
                w_enc = {imm[11:0], rs1, funct3, rd, op};
            c_OP_STORE:
                w_enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
            c_OP_BRANCH:
                w_enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
            c_OP_LUI, c_OP_AUIPC:
                w_enc = {imm[INSTR_WIDTH-1:12], rd, op};
            c_OP_JAL:
                w_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default:
                w_illegal = 1'b1;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic w_fits_s12;
    logic w_fits_s13;
    logic w_fits_s21;

    // A signed N-bit value has all bits above N-1 equal to its sign bit.
    assign w_fits_s12 = (imm[INSTR_WIDTH-1:11] == {(INSTR_WIDTH-11){imm[11]}});
    assign w_fits_s13 = (imm[INSTR_WIDTH-1:12] == {(INSTR_WIDTH-12){imm[12]}});
    assign w_fits_s21 = (imm[INSTR_WIDTH-1:20] == {(INSTR_WIDTH-20){imm[20]}});

    always_comb begin
        w_range_err = 1'b0;
        case (op)
            c_OP_IMM: begin
                if ((funct3 == 3'b001) || (funct3 == 3'b101))
                    w_range_err = |imm[INSTR_WIDTH-1:5];
                else
                    w_range_err = ~w_fits_s12;
            end
            c_OP_JALR, c_OP_LOAD, c_OP_MISC, c_OP_SYSTEM, c_OP_STORE:
                w_range_err = ~w_fits_s12;
            c_OP_BRANCH:
                w_range_err = ~w_fits_s13 | imm[0];
            c_OP_LUI, c_OP_AUIPC:
                w_range_err = |imm[11:0];
            c_OP_JAL:
                w_range_err = ~w_fits_s21 | imm[0];
            default:
                w_range_err = 1'b0;
        endcase
    end
`else
    assign w_range_err = 1'b0;
`endif

    assign in_ready  = (r_state_q == c_RUN) && (r_count_q != 2'd2);
    assign out_valid = (r_count_q != 2'd0);
    assign out_instr = out_valid ? r_mem_instr_q[r_rd_ptr_q] : '0;
    assign out_addr  = out_valid ? r_mem_addr_q[r_rd_ptr_q]  : '0;
    assign busy      = (r_state_q != c_IDLE);
    assign err       = r_err_q;
    assign err_code  = r_err_code_q;

    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & ~w_illegal & ~w_range_err;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            c_IDLE: begin
                if (start) begin
                    w_state_d = c_RUN;
                    w_cnt_d   = base_addr;
                end
            end
            c_RUN:   if (stop) w_state_d = c_DRAIN;
            c_DRAIN: if (r_count_q == 2'd0) w_state_d = c_IDLE;
            default: w_state_d = c_IDLE;
        endcase
        // Pushes only happen in RUN, so they never collide with the base load.
        if (w_push) w_cnt_d = r_cnt_q + c_ADDR_STEP;
    end

    always_comb begin
        w_mem_instr_d = r_mem_instr_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_wr_ptr_d    = r_wr_ptr_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_count_d     = r_count_q;
        if (w_push) begin
            w_mem_instr_d[r_wr_ptr_q] = w_enc;
            w_mem_addr_d[r_wr_ptr_q]  = r_cnt_q;
            w_wr_ptr_d                = ~r_wr_ptr_q;
        end
        if (w_pop) w_rd_ptr_d = ~r_rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 2'd1;
            2'b01:   w_count_d = r_count_q - 2'd1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_comb begin
        w_err_d      = r_err_q;
        w_err_code_d = r_err_code_q;
        if (w_accept && (w_illegal || w_range_err)) begin
            w_err_d      = 1'b1;
            w_err_code_d = w_illegal ? 2'b01 : 2'b10;
        end else if (err_clr) begin
            w_err_d      = 1'b0;
            w_err_code_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= c_IDLE;
            r_cnt_q       <= '0;
            r_mem_instr_q <= '0;
            r_mem_addr_q  <= '0;
            r_wr_ptr_q    <= 1'b0;
            r_rd_ptr_q    <= 1'b0;
            r_count_q     <= 2'd0;
            r_err_q       <= 1'b0;
            r_err_code_q  <= 2'b00;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_mem_instr_q <= w_mem_instr_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_count_q     <= w_count_d;
            r_err_q       <= w_err_d;
            r_err_code_q  <= w_err_code_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Self-checking bench for instr_encoder: known-answer vectors,
//            hand sequences and random traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int c_IDLE  = 0;
    localparam int c_RUN   = 1;
    localparam int c_DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  op = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic        alt_op = 1'b0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_addr;
    logic        busy, err;
    logic [1:0]  err_code;
    logic        err_clr = 1'b0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .alt_op(alt_op), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .busy(busy),
        .err(err), .err_code(err_code), .err_clr(err_clr)
    );

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } ent_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_oor    = 0;
    ent_t        exp_q[$];
    int          m_st;
    logic [31:0] m_cnt;
    logic        m_err;
    logic [1:0]  m_code;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: places each immediate/register field by shift-and-mask.
    function automatic void model_enc(input logic [6:0] o, input logic [4:0] d, s1, s2,
                                      input logic [2:0] f, input logic a, input logic [31:0] i,
                                      output logic [31:0] w, output logic [1:0] ec,
                                      output logic oor);
        logic [31:0] ro, rdv, r1, r2, fv, ity;
        int si;
        ro  = 32'(o);
        rdv = 32'(d) << 7;
        r1  = 32'(s1) << 15;
        r2  = 32'(s2) << 20;
        fv  = 32'(f) << 12;
        si  = $signed(i);
        ity = ((i & 32'hFFF) << 20) | r1 | fv | rdv | ro;
        w   = '0;
        ec  = 2'b00;
        oor = 1'b0;
        case (o)
            7'h33: w = r2 | r1 | fv | rdv | ro | (((f == 0 || f == 5) && a) ? 32'h4000_0000 : 32'h0);
            7'h13: begin
                if (f == 1 || f == 5) begin
                    w   = ((i & 32'h1F) << 20) | r1 | fv | rdv | ro | ((f == 5 && a) ? 32'h4000_0000 : 32'h0);
                    oor = (i >> 5) != 0;
                end else begin
                    w   = ity;
                    oor = si < -2048 || si > 2047;
                end
            end
            7'h67, 7'h03, 7'h0F, 7'h73: begin
                w   = ity;
                oor = si < -2048 || si > 2047;
            end
            7'h23: begin
                w   = (((i >> 5) & 32'h7F) << 25) | r2 | r1 | fv | ((i & 32'h1F) << 7) | ro;
                oor = si < -2048 || si > 2047;
            end
            7'h63: begin
                w   = (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | r2 | r1 | fv
                    | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7) | ro;
                oor = si < -4096 || si > 4095 || i[0];
            end
            7'h37, 7'h17: begin
                w   = (i & 32'hFFFF_F000) | rdv | ro;
                oor = (i & 32'hFFF) != 0;
            end
            7'h6F: begin
                w   = (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                    | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12) | rdv | ro;
                oor = si < -1048576 || si > 1048575 || i[0];
            end
            default: ec = 2'b01;
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        if (ec == 2'b00 && oor) ec = 2'b10;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_st   = c_IDLE;
        m_cnt  = '0;
        m_err  = 1'b0;
        m_code = 2'b00;
    endtask

    // Called at a falling edge with inputs set: checks outputs, advances the
    // model across the next rising edge, returns at the following falling edge.
    task automatic cycle();
        logic [31:0] w;
        logic [1:0]  ec;
        logic        oor, acc, pop;
        int          sz;
        sz = exp_q.size();
        chk("out_valid", 32'(out_valid), 32'(sz != 0));
        chk("in_ready", 32'(in_ready), 32'(m_st == c_RUN && sz < 2));
        chk("busy", 32'(busy), 32'(m_st != c_IDLE));
        chk("err", 32'(err), 32'(m_err));
        chk("err_code", 32'(err_code), 32'(m_code));
        if (sz != 0) begin
            chk("out_instr", out_instr, exp_q[0].instr);
            chk("out_addr", out_addr, exp_q[0].addr);
        end
        acc = in_valid && m_st == c_RUN && sz < 2;
        pop = (sz != 0) && out_ready;
        ec  = 2'b00;
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            model_enc(op, rd, rs1, rs2, funct3, alt_op, imm, w, ec, oor);
            if (oor) n_oor++;
            if (ec == 2'b00) begin
                exp_q.push_back('{instr: w, addr: m_cnt});
                m_cnt = m_cnt + 32'd4;
            end
        end
        if (acc && ec != 2'b00) begin
            m_err  = 1'b1;
            m_code = ec;
        end else if (err_clr) begin
            m_err  = 1'b0;
            m_code = 2'b00;
        end
        case (m_st)
            c_IDLE:  if (start) begin m_st = c_RUN; m_cnt = base_addr; end
            c_RUN:   if (stop) m_st = c_DRAIN;
            default: if (sz == 0) m_st = c_IDLE;
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_fields(input vec_t v);
        op = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; alt_op = v.alt; imm = v.imm;
    endtask

    function automatic vec_t mk_addi(input logic [4:0] d, input logic [31:0] i);
        vec_t v;
        v = '{op: 7'h13, rd: d, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, alt: 1'b0, imm: i, exp: 32'h0};
        return v;
    endfunction

    task automatic begin_run(input logic [31:0] base);
        base_addr = base; start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic end_run();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6 && busy; c++) cycle();
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    vec_t        tbl[9];
    logic [31:0] seen[$];
    logic [6:0]  legal_ops[11] = '{7'h33, 7'h13, 7'h03, 7'h0F, 7'h73, 7'h67,
                                   7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5,          32'h00500093};
        tbl[1] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0,          32'h402081B3};
        tbl[2] = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd12,         32'h0020A623};
        tbl[3] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFF8,  32'hFE208CE3};
        tbl[4] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h800,        32'h001000EF};
        tbl[5] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000,  32'h123452B7};
        tbl[6] = '{7'h13, 5'd2, 5'd3, 5'd0, 3'd5, 1'b1, 32'd4,          32'h4041D113};
        tbl[7] = '{7'h03, 5'd4, 5'd2, 5'd0, 3'd2, 1'b0, 32'hFFFF_FFFC,  32'hFFC12203};
        tbl[8] = '{7'h33, 5'd1, 5'd2, 5'd3, 3'd1, 1'b1, 32'd0,          32'h003110B3};

        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Known-answer vectors, one at a time, latency 1
        begin_run(32'h100);
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            set_fields(tbl[k]);
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_instr", out_instr, tbl[k].exp);
            chk("tbl_addr", out_addr, 32'h100 + 32'(4 * k));
            cycle();
        end
        end_run();

        // Backpressure: third set waits until the FIFO frees a slot
        begin_run(32'h100);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_fields(mk_addi(5'(k + 1), 32'(k)));
            in_valid = 1'b1;
            cycle();
        end
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_valid_hold", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        seen.delete();
        for (int c = 0; c < 8; c++) begin
            logic took;
            took = in_valid && in_ready;
            if (out_valid) seen.push_back(out_addr);
            cycle();
            if (took) in_valid = 1'b0;
        end
        chk("bp_count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("bp_addr0", seen[0], 32'h100);
            chk("bp_addr1", seen[1], 32'h104);
            chk("bp_addr2", seen[2], 32'h108);
        end
        end_run();

        // Errors: illegal opcode consumed without advancing the address
        begin_run(32'h300);
        op = 7'h00; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_code", 32'(err_code), 32'd1);
        chk("ill_no_out", 32'(out_valid), 32'd0);
        set_fields(mk_addi(5'd7, 32'd9)); in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("ill_addr", out_addr, 32'h300);
        op = 7'h7F; in_valid = 1'b1; err_clr = 1'b1;
        cycle();
        in_valid = 1'b0; err_clr = 1'b0;
        chk("clr_vs_new", 32'(err), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_code", 32'(err_code), 32'd0);
        set_fields(mk_addi(5'd1, 32'd2048)); in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        chk("rng_code", 32'(err_code), 32'd2);
        chk("rng_no_out", 32'(out_valid), 32'd0);
`else
        chk("trunc_no_err", 32'(err), 32'd0);
        chk("trunc_instr", out_instr, 32'h80000093);
`endif
        cycle();
        end_run();

        // Asynchronous reset with two entries buffered
        begin_run(32'h100);
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_fields(mk_addi(5'(k + 3), 32'(k)));
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_instr", out_instr, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        begin_run(32'h200);
        out_ready = 1'b1;
        set_fields(mk_addi(5'd1, 32'd1)); in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("arst_restart_addr", out_addr, 32'h200);
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom % 3) != 0;
            op        = ($urandom % 8 == 0) ? 7'($urandom) : legal_ops[$urandom % 11];
            rd        = 5'($urandom);
            rs1       = 5'($urandom);
            rs2       = 5'($urandom);
            funct3    = 3'($urandom);
            alt_op    = 1'($urandom);
            case ($urandom % 4)
                0:       imm = 32'(int'($urandom_range(0, 63)) - 32);
                1:       imm = $urandom;
                2:       imm = $urandom & 32'hFFFF_F000;
                default: imm = 32'($urandom_range(0, 4095));
            endcase
            out_ready = ($urandom % 4) != 0;
            start     = ($urandom % 16) == 0;
            stop      = ($urandom % 48) == 0;
            err_clr   = ($urandom % 8) == 0;
            base_addr = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            cycle();
        end
        in_valid = 1'b0; start = 1'b0; err_clr = 1'b0;
        end_run();

        $display("info: out-of-range immediates offered = %0d", n_oor);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
